// File: rtl/tx_link_arbiter_if.sv
// rtl/tx_link_arbiter_if.sv - requester and transmitter signal bundle for tx_link_arbiter
interface tx_link_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 55
);
  logic [N_REQ-1:0]        Req_Valid;
  logic [N_REQ*DATA_W-1:0] Req_Data;
  logic [N_REQ-1:0]        Req_Mask;
  logic [N_REQ-1:0]        Req_Ack;
  logic [N_REQ-1:0]        Grant;
  logic [DATA_W-1:0]       TX_Data;
  logic                    TX_Data_Valid;
  logic                    TX_Ready;
  logic                    Link_Busy;
  logic                    Timeout_Err;

  modport master (
    input  Req_Valid, Req_Data, Req_Mask, TX_Ready,
    output Req_Ack, Grant, TX_Data, TX_Data_Valid, Link_Busy, Timeout_Err
  );

  modport slave (
    output Req_Valid, Req_Data, Req_Mask, TX_Ready,
    input  Req_Ack, Grant, TX_Data, TX_Data_Valid, Link_Busy, Timeout_Err
  );
endinterface

// File: rtl/tx_link_arbiter.sv
// rtl/tx_link_arbiter.sv - round-robin arbiter sharing one serial transmitter among N_REQ requesters
module tx_link_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 55,
  parameter int TIMEOUT = 1023
) (
  input  logic               Clk_S,
  input  logic               Rst_n,
  tx_link_arbiter_if.master  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd2;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd3;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W:0]    rr_idx;
  logic              any_elig;
  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  win_onehot;
  logic [DATA_W-1:0] win_data;
  logic [DATA_W-1:0] hold;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              exit_cond;
  logic              tmo_hit;
  logic [N_REQ-1:0]  ack_r;
  logic [N_REQ-1:0]  grant_r;
  logic              valid_r;
  logic              tmo_r;

  assign elig = bus.Req_Valid & ~bus.Req_Mask;

  // Walk offsets from the far end back to 0 so the nearest eligible index after ptr wins.
  always_comb begin
    any_elig = 1'b0;
    winner   = '0;
    rr_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      rr_idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (rr_idx >= (PTR_W+1)'(N_REQ))
        rr_idx = rr_idx - (PTR_W+1)'(N_REQ);
      if (elig[rr_idx[PTR_W-1:0]]) begin
        winner   = rr_idx[PTR_W-1:0];
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == PTR_W'(i))
        win_data = bus.Req_Data[i*DATA_W +: DATA_W];
    end
  end

  assign win_onehot = N_REQ'(1) << winner;

  always_comb begin
    exit_cond = 1'b0;
    case (state)
      ST_SEND:      exit_cond = bus.TX_Ready;
      ST_WAIT_LOW:  exit_cond = ~bus.TX_Ready;
      ST_WAIT_HIGH: exit_cond = bus.TX_Ready;
      default:      exit_cond = 1'b0;
    endcase
  end

  // A legitimate exit on the same edge as the last allowed cycle takes priority over the abort.
  assign tmo_hit = (state != ST_IDLE) && !exit_cond && (tmo_cnt == CNT_MAX);

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      hold    <= '0;
      tmo_cnt <= '0;
      ack_r   <= '0;
      grant_r <= '0;
      valid_r <= 1'b0;
      tmo_r   <= 1'b0;
    end else begin
      ack_r <= '0;
      tmo_r <= 1'b0;
      if (state == ST_IDLE) begin
        tmo_cnt <= '0;
        if (any_elig) begin
          hold    <= win_data;
          ack_r   <= win_onehot;
          grant_r <= win_onehot;
          valid_r <= 1'b1;
          state   <= ST_SEND;
          ptr     <= (winner == PTR_LAST) ? '0 : winner + PTR_W'(1);
        end
      end else if (exit_cond) begin
        tmo_cnt <= '0;
        if (state == ST_SEND) begin
          valid_r <= 1'b0;
          state   <= ST_WAIT_LOW;
        end else if (state == ST_WAIT_LOW) begin
          state   <= ST_WAIT_HIGH;
        end else begin
          grant_r <= '0;
          state   <= ST_IDLE;
        end
      end else if (tmo_hit) begin
        tmo_cnt <= '0;
        grant_r <= '0;
        valid_r <= 1'b0;
        tmo_r   <= 1'b1;
        state   <= ST_IDLE;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.Req_Ack       = ack_r;
  assign bus.Grant         = grant_r;
  assign bus.TX_Data       = hold;
  assign bus.TX_Data_Valid = valid_r;
  assign bus.Timeout_Err   = tmo_r;
  assign bus.Link_Busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_tx_link_arbiter.sv
// tb/tb_tx_link_arbiter.sv - directed self-checking bench for tx_link_arbiter
module tb_tx_link_arbiter;

  localparam int N  = 4;
  localparam int DW = 55;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic auto_tx = 1'b0;
  logic man_ready = 1'b1;
  logic model_ready = 1'b1;
  int   busy_cnt = 0;
  logic [DW-1:0] rx_shift = '0;
  logic [DW-1:0] rx_data = '0;
  logic rx_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_data [N];
  int            exp_ord [8];
  logic [3:0]    q_ack [$];
  logic [3:0]    q_gnt [$];
  logic [DW-1:0] q_dat [$];
  int            q_t [$];
  logic [DW-1:0] q_rx [$];
  int            ack1_cnt;

  tx_link_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  tx_link_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(16)) dut (
    .Clk_S (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.TX_Ready = auto_tx ? model_ready : man_ready;

  // Transmitter/receiver stand-in: accepts a word, drops ready for three cycles, then delivers it.
  always @(posedge clk) begin
    rx_valid <= 1'b0;
    if (!auto_tx) begin
      model_ready <= 1'b1;
      busy_cnt    <= 0;
    end else if (model_ready && bus.TX_Data_Valid) begin
      model_ready <= 1'b0;
      rx_shift    <= bus.TX_Data;
      busy_cnt    <= 2;
    end else if (!model_ready) begin
      if (busy_cnt == 0) begin
        model_ready <= 1'b1;
        rx_valid    <= 1'b1;
        rx_data     <= rx_shift;
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic collect(input int n, input int bound);
    int cyc;
    cyc = 0;
    ack1_cnt = 0;
    q_ack.delete(); q_gnt.delete(); q_dat.delete(); q_t.delete();
    while (q_ack.size() < n && cyc < bound) begin
      step();
      cyc++;
      if (bus.Req_Ack[1]) ack1_cnt++;
      if (bus.Req_Ack != '0) begin
        q_ack.push_back(bus.Req_Ack);
        q_gnt.push_back(bus.Grant);
        q_dat.push_back(bus.TX_Data);
        q_t.push_back(cyc);
      end
    end
  endtask

  task automatic check_order(input string tag, input int n);
    logic [3:0] oh;
    chk({tag, "_count"}, 64'(q_ack.size()), 64'(n));
    for (int k = 0; k < n && k < q_ack.size(); k++) begin
      oh = 4'(1 << exp_ord[k]);
      chk({tag, "_ack"},   64'(q_ack[k]), 64'(oh));
      chk({tag, "_grant"}, 64'(q_gnt[k]), 64'(oh));
      chk({tag, "_data"},  64'(q_dat[k]), 64'(exp_data[exp_ord[k]]));
      if (k > 0) chk({tag, "_spacing"}, 64'(q_t[k] - q_t[k-1]), 64'(6));
    end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int cyc;
    cyc = 0;
    step();
    while (bus.Link_Busy && cyc < bound) begin
      step();
      cyc++;
    end
    chk(tag, 64'(bus.Link_Busy), 64'(0));
  endtask

  initial begin
    exp_data[0] = 55'h0abcd;
    exp_data[1] = 55'h11_1111;
    exp_data[2] = 55'h1234;
    exp_data[3] = 55'h7f_0000_3333;
    bus.Req_Valid = '0;
    bus.Req_Mask  = '0;
    for (int i = 0; i < N; i++) bus.Req_Data[i*DW +: DW] = exp_data[i];

    step(); step();
    chk("rst_grant",   64'(bus.Grant), 64'(0));
    chk("rst_valid",   64'(bus.TX_Data_Valid), 64'(0));
    chk("rst_busy",    64'(bus.Link_Busy), 64'(0));
    chk("rst_ack",     64'(bus.Req_Ack), 64'(0));
    chk("rst_tmo",     64'(bus.Timeout_Err), 64'(0));
    chk("rst_data",    64'(bus.TX_Data), 64'(0));
    rst_n = 1'b1;
    step();
    chk("idle_no_grant", 64'(bus.Grant), 64'(0));

    // single word from requester 0, transmitter stalls acceptance for two cycles
    bus.Req_Valid = 4'b0001;
    step();
    chk("s2_ack",   64'(bus.Req_Ack), 64'(4'b0001));
    chk("s2_grant", 64'(bus.Grant), 64'(4'b0001));
    chk("s2_data",  64'(bus.TX_Data), 64'(55'h0abcd));
    chk("s2_valid", 64'(bus.TX_Data_Valid), 64'(1));
    chk("s2_busy",  64'(bus.Link_Busy), 64'(1));
    bus.Req_Valid = '0;
    man_ready = 1'b0;
    step();
    chk("s2_ack_pulse", 64'(bus.Req_Ack), 64'(0));
    chk("s2_hold1", 64'(bus.TX_Data_Valid), 64'(1));
    step();
    chk("s2_hold2", 64'(bus.TX_Data_Valid), 64'(1));
    man_ready = 1'b1;
    step();
    chk("s2_accept_valid", 64'(bus.TX_Data_Valid), 64'(0));
    chk("s2_accept_busy",  64'(bus.Link_Busy), 64'(1));
    chk("s2_accept_grant", 64'(bus.Grant), 64'(4'b0001));
    man_ready = 1'b0;
    step();
    chk("s2_wait_high_busy", 64'(bus.Link_Busy), 64'(1));
    man_ready = 1'b1;
    step();
    chk("s2_done_busy",  64'(bus.Link_Busy), 64'(0));
    chk("s2_done_grant", 64'(bus.Grant), 64'(0));
    chk("s2_data_kept",  64'(bus.TX_Data), 64'(55'h0abcd));

    // reset in the middle of SEND; pointer had advanced to 1
    bus.Req_Valid = 4'b1111;
    man_ready = 1'b0;
    step();
    chk("s1_pre_grant", 64'(bus.Grant), 64'(4'b0010));
    step();
    chk("s1_in_send", 64'(bus.TX_Data_Valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("s1_async_grant", 64'(bus.Grant), 64'(0));
    chk("s1_async_valid", 64'(bus.TX_Data_Valid), 64'(0));
    chk("s1_async_busy",  64'(bus.Link_Busy), 64'(0));
    step();
    rst_n = 1'b1;
    auto_tx = 1'b1;

    // round-robin with all requesters valid
    exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 2; exp_ord[3] = 3; exp_ord[4] = 0;
    collect(5, 60);
    bus.Req_Valid = '0;
    check_order("rr", 5);
    wait_idle("rr_idle", 20);

    // mask requester 1
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.Req_Mask  = 4'b0010;
    bus.Req_Valid = 4'b1111;
    exp_ord[0] = 0; exp_ord[1] = 2; exp_ord[2] = 3; exp_ord[3] = 0;
    collect(4, 60);
    bus.Req_Valid = '0;
    check_order("mask", 4);
    chk("mask_ack1_never", 64'(ack1_cnt), 64'(0));
    wait_idle("mask_idle", 20);
    bus.Req_Mask = '0;

    // timeout in SEND; pointer is at 1 so requester 2 wins, then requester 0
    auto_tx = 1'b0;
    man_ready = 1'b0;
    bus.Req_Valid = 4'b0101;
    step();
    chk("tmo_grant", 64'(bus.Grant), 64'(4'b0100));
    chk("tmo_ack",   64'(bus.Req_Ack), 64'(4'b0100));
    bus.Req_Valid = 4'b0001;
    for (int i = 0; i < 15; i++) step();
    chk("tmo_last_valid", 64'(bus.TX_Data_Valid), 64'(1));
    chk("tmo_not_yet",    64'(bus.Timeout_Err), 64'(0));
    step();
    chk("tmo_pulse", 64'(bus.Timeout_Err), 64'(1));
    chk("tmo_valid", 64'(bus.TX_Data_Valid), 64'(0));
    chk("tmo_grant0", 64'(bus.Grant), 64'(0));
    chk("tmo_busy",  64'(bus.Link_Busy), 64'(0));
    step();
    chk("tmo_pulse_end", 64'(bus.Timeout_Err), 64'(0));
    chk("tmo_next_grant", 64'(bus.Grant), 64'(4'b0001));
    chk("tmo_next_ack",   64'(bus.Req_Ack), 64'(4'b0001));
    bus.Req_Valid = '0;
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    step();
    man_ready = 1'b1;
    step();
    chk("tmo_recover_idle", 64'(bus.Link_Busy), 64'(0));

    // end-to-end through the transmitter/receiver stand-in
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    auto_tx = 1'b1;
    bus.Req_Valid = 4'b0101;
    q_rx.delete();
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.Req_Ack[0]) bus.Req_Valid[0] = 1'b0;
      if (bus.Req_Ack[2]) bus.Req_Valid[2] = 1'b0;
      if (rx_valid) q_rx.push_back(rx_data);
    end
    chk("e2e_count", 64'(q_rx.size()), 64'(2));
    if (q_rx.size() > 0) chk("e2e_word0", 64'(q_rx[0]), 64'(55'h0abcd));
    if (q_rx.size() > 1) chk("e2e_word1", 64'(q_rx[1]), 64'(55'h1234));
    chk("e2e_idle", 64'(bus.Link_Busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
